// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the Mini SRC control sequencer: opcodes, ALU codes,
// sequencer states and the instruction classes that select execute sequences.
`timescale 1ns/1ps
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU3, C_ALUI, C_BR, C_JR, C_JAL,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } instr_class_t;

  // True in the final step of an instruction's sequence.
  function automatic logic is_last_step(state_t s, instr_class_t c);
    logic last;
    last = 1'b0;
    case (s)
      S_T2:    last = (c == C_NOP) || (c == C_HALT);
      S_T3:    last = (c == C_JR) || (c == C_IN) || (c == C_OUT) ||
                      (c == C_MFHI) || (c == C_MFLO);
      S_T4:    last = (c == C_JAL);
      S_T5:    last = (c == C_LDI) || (c == C_ALU3) || (c == C_ALUI);
      S_T6:    last = (c == C_BR);
      S_T7:    last = 1'b1;
      default: last = 1'b0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Opcode to instruction-class and ALU-operation decoder; anything not listed,
// including mul/div/neg/not, falls through to the nop class.
`timescale 1ns/1ps
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t iclass,
  output logic [4:0]   alu_code
);

  always_comb begin
    iclass   = C_NOP;
    alu_code = ALU_ADD;
    case (opcode) inside
      OP_LD:           iclass = C_LD;
      OP_LDI:          iclass = C_LDI;
      OP_ST:           iclass = C_ST;
      [OP_ADD:OP_SHL]: begin
        iclass   = C_ALU3;
        alu_code = opcode;
      end
      OP_ADDI:         iclass = C_ALUI;
      OP_ANDI: begin
        iclass   = C_ALUI;
        alu_code = ALU_AND;
      end
      OP_ORI: begin
        iclass   = C_ALUI;
        alu_code = ALU_OR;
      end
      OP_BR:           iclass = C_BR;
      OP_JR:           iclass = C_JR;
      OP_JAL:          iclass = C_JAL;
      OP_IN:           iclass = C_IN;
      OP_OUT:          iclass = C_OUT;
      OP_MFHI:         iclass = C_MFHI;
      OP_MFLO:         iclass = C_MFLO;
      OP_HALT:         iclass = C_HALT;
      OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_NOP: iclass = C_NOP;
      default:         iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Mini SRC: shared fetch T0-T2, per-class execute
// T3-T7. State advances on the falling clock edge so strobes settle before capture.
`timescale 1ns/1ps
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, R15in,
  output logic        read, write, RAMenable,
  output logic        Cout, ZLOin, ZLOout, ZHIout, ZMuxEnable, ZMuxOut, ZSelect, conin,
  output logic        OutPortenable, PortInout,
  output logic [4:0]  aluControl
);

  state_t       state, next_state;
  instr_class_t iclass;
  logic [4:0]   alu_code;
  logic         stop_pending;
  logic         unused_ir;

  assign unused_ir = ^IR[26:0];

  instr_class_decode u_decode (
    .opcode   (IR[31:27]),
    .iclass   (iclass),
    .alu_code (alu_code)
  );

  // A stop pulse seen at any edge is remembered until the running instruction ends.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      state        <= S_T0;
      stop_pending <= 1'b0;
    end else begin
      state        <= next_state;
      stop_pending <= stop_pending | stop;
    end
  end

  always_comb begin
    next_state = state;
    if (state == S_HALT) begin
      next_state = S_HALT;
    end else if (is_last_step(state, iclass)) begin
      next_state = (iclass == C_HALT || stop || stop_pending) ? S_HALT : S_T0;
    end else begin
      case (state)
        S_T0:    next_state = S_T1;
        S_T1:    next_state = S_T2;
        S_T2:    next_state = S_T3;
        S_T3:    next_state = S_T4;
        S_T4:    next_state = S_T5;
        S_T5:    next_state = S_T6;
        S_T6:    next_state = S_T7;
        default: next_state = S_T0;
      endcase
    end
  end

  always_comb begin
    run = 1'b1;
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; R15in = 1'b0;
    read = 1'b0; write = 1'b0; RAMenable = 1'b0;
    Cout = 1'b0; ZLOin = 1'b0; ZLOout = 1'b0; ZHIout = 1'b0;
    ZMuxEnable = 1'b0; ZMuxOut = 1'b0; ZSelect = 1'b0; conin = 1'b0;
    OutPortenable = 1'b0; PortInout = 1'b0;
    aluControl = ALU_NONE;
    if (clear) begin
      case (state)
        S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
        S_T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
        S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T3: begin
          case (iclass)
            C_LD, C_LDI, C_ST, C_ALU3, C_ALUI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_BR:   begin Gra = 1'b1; Rout = 1'b1; conin = 1'b1; end
            C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            C_JAL:  begin PCout = 1'b1; R15in = 1'b1; end
            C_IN:   begin PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1; end
            C_MFHI: begin ZHIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_MFLO: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        S_T4: begin
          case (iclass)
            C_LD, C_LDI, C_ST, C_ALUI: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = alu_code; end
            C_ALU3: begin Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; aluControl = alu_code; end
            C_BR:   begin PCout = 1'b1; Yin = 1'b1; end
            C_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
        S_T5: begin
          case (iclass)
            C_LD, C_ST: begin ZMuxEnable = 1'b1; ZMuxOut = 1'b1; MARin = 1'b1; end
            C_LDI, C_ALU3, C_ALUI: begin ZMuxEnable = 1'b1; ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_BR: begin Cout = 1'b1; ZLOin = 1'b1; aluControl = ALU_ADD; end
            default: ;
          endcase
        end
        S_T6: begin
          case (iclass)
            C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_LD: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
            C_BR: begin ZMuxEnable = 1'b1; ZMuxOut = 1'b1; PCin = CON; end
            default: ;
          endcase
        end
        S_T7: begin
          case (iclass)
            C_ST: begin write = 1'b1; RAMenable = 1'b1; end
            C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        S_HALT: run = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a step-counting instruction model predicts
// every strobe each cycle, and directed literal checks pin the model itself.
`timescale 1ns/1ps
module tb_control_unit;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic [31:0] IR = 32'h0;
  logic CON = 1'b0;
  logic stop = 1'b0;
  logic run;
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, R15in;
  logic read, write, RAMenable;
  logic Cout, ZLOin, ZLOout, ZHIout, ZMuxEnable, ZMuxOut, ZSelect, conin;
  logic OutPortenable, PortInout;
  logic [4:0] aluControl;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop), .run(run),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .R15in(R15in), .read(read),
    .write(write), .RAMenable(RAMenable), .Cout(Cout), .ZLOin(ZLOin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .ZMuxEnable(ZMuxEnable), .ZMuxOut(ZMuxOut),
    .ZSelect(ZSelect), .conin(conin), .OutPortenable(OutPortenable),
    .PortInout(PortInout), .aluControl(aluControl)
  );

  always #5 clock = ~clock;

  localparam logic [27:0] PCOUT   = 28'b1 << 0;
  localparam logic [27:0] INCPC   = 28'b1 << 1;
  localparam logic [27:0] PCIN    = 28'b1 << 2;
  localparam logic [27:0] MARIN   = 28'b1 << 3;
  localparam logic [27:0] MDRIN   = 28'b1 << 4;
  localparam logic [27:0] MDROUT  = 28'b1 << 5;
  localparam logic [27:0] IRIN    = 28'b1 << 6;
  localparam logic [27:0] YIN     = 28'b1 << 7;
  localparam logic [27:0] GRA     = 28'b1 << 8;
  localparam logic [27:0] GRB     = 28'b1 << 9;
  localparam logic [27:0] GRC     = 28'b1 << 10;
  localparam logic [27:0] RIN     = 28'b1 << 11;
  localparam logic [27:0] ROUT    = 28'b1 << 12;
  localparam logic [27:0] R15IN   = 28'b1 << 14;
  localparam logic [27:0] READ    = 28'b1 << 15;
  localparam logic [27:0] WRITE   = 28'b1 << 16;
  localparam logic [27:0] RAMEN   = 28'b1 << 17;
  localparam logic [27:0] COUT    = 28'b1 << 18;
  localparam logic [27:0] ZLOIN   = 28'b1 << 19;
  localparam logic [27:0] ZLOOUT  = 28'b1 << 20;
  localparam logic [27:0] ZHIOUT  = 28'b1 << 21;
  localparam logic [27:0] ZOUT    = (28'b1 << 22) | (28'b1 << 23);
  localparam logic [27:0] CONIN   = 28'b1 << 25;
  localparam logic [27:0] OUTPORT = 28'b1 << 26;
  localparam logic [27:0] PORTIN  = 28'b1 << 27;

  logic [33:0] dutVec;
  assign dutVec = {run, aluControl, PortInout, OutPortenable, conin, ZSelect,
                   ZMuxOut, ZMuxEnable, ZHIout, ZLOout, ZLOin, Cout, RAMenable,
                   write, read, R15in, BAout, Rout, Rin, Grc, Grb, Gra, Yin,
                   IRin, MDRout, MDRin, MARin, PCin, IncPC, PCout};

  int total = 0;
  int bad = 0;
  bit done = 1'b0;
  logic [31:0] pendingIr = 32'h0;
  logic [33:0] snap [8];

  int mStep = 0;
  bit mHalted = 1'b0;
  bit mStopReq = 1'b0;

  function automatic string kindOf(logic [4:0] op);
    int o;
    o = int'(op);
    if (o == 0) return "ld";
    if (o == 1) return "ldi";
    if (o == 2) return "st";
    if (o >= 3 && o <= 11) return "alu3";
    if (o >= 12 && o <= 14) return "alui";
    if (o == 19) return "br";
    if (o == 20) return "jr";
    if (o == 21) return "jal";
    if (o == 22) return "in";
    if (o == 23) return "out";
    if (o == 24) return "mfhi";
    if (o == 25) return "mflo";
    if (o == 27) return "halt";
    return "nop";
  endfunction

  function automatic int latencyOf(logic [4:0] op);
    string k;
    k = kindOf(op);
    if (k == "ld" || k == "st") return 8;
    if (k == "br") return 7;
    if (k == "ldi" || k == "alu3" || k == "alui") return 6;
    if (k == "jal") return 5;
    if (k == "nop" || k == "halt") return 3;
    return 4;
  endfunction

  function automatic logic [33:0] expectVec(bit halted, bit clrLow, int step,
                                            logic [4:0] op, logic con);
    logic [27:0] s;
    logic [4:0] alu;
    string k;
    s = 28'h0;
    alu = 5'd0;
    k = kindOf(op);
    if (clrLow) return {1'b1, 33'b0};
    if (halted) return 34'b0;
    if (step == 0) s = PCOUT | MARIN | INCPC;
    else if (step == 1) s = READ | RAMEN | MDRIN;
    else if (step == 2) s = MDROUT | IRIN;
    else if (k == "ld" || k == "st" || k == "ldi" || k == "alu3" || k == "alui") begin
      if (step == 3) s = GRB | ROUT | YIN;
      else if (step == 4) begin
        s = (k == "alu3") ? (GRC | ROUT | ZLOIN) : (COUT | ZLOIN);
        if (k == "alu3") alu = op;
        else if (op == 5'd13) alu = 5'd5;
        else if (op == 5'd14) alu = 5'd6;
        else alu = 5'd3;
      end
      else if (step == 5) s = (k == "ld" || k == "st") ? (ZOUT | MARIN) : (ZOUT | GRA | RIN);
      else if (step == 6) s = (k == "st") ? (GRA | ROUT | MDRIN) : (READ | RAMEN | MDRIN);
      else if (step == 7) s = (k == "st") ? (WRITE | RAMEN) : (MDROUT | GRA | RIN);
    end
    else if (k == "br") begin
      if (step == 3) s = GRA | ROUT | CONIN;
      else if (step == 4) s = PCOUT | YIN;
      else if (step == 5) begin s = COUT | ZLOIN; alu = 5'd3; end
      else if (step == 6) s = con ? (ZOUT | PCIN) : ZOUT;
    end
    else if (k == "jal") s = (step == 3) ? (PCOUT | R15IN) : (GRA | ROUT | PCIN);
    else if (k == "jr") s = GRA | ROUT | PCIN;
    else if (k == "in") s = PORTIN | GRA | RIN;
    else if (k == "out") s = GRA | ROUT | OUTPORT;
    else if (k == "mfhi") s = ZHIOUT | GRA | RIN;
    else if (k == "mflo") s = ZLOOUT | GRA | RIN;
    return {1'b1, alu, s};
  endfunction

  // Instruction-level model: counts steps of the current instruction.
  always @(negedge clock or negedge clear) begin
    if (!clear) begin
      mStep = 0;
      mHalted = 1'b0;
      mStopReq = 1'b0;
    end else if (!mHalted) begin
      if (stop) mStopReq = 1'b1;
      if (mStep == latencyOf(IR[31:27]) - 1) begin
        if (kindOf(IR[31:27]) == "halt" || mStopReq) mHalted = 1'b1;
        mStep = 0;
      end else begin
        mStep = mStep + 1;
      end
    end
  end

  // Datapath stand-in: IR takes the pending word when IRin is seen at the rising edge.
  initial begin
    logic ldFlag;
    forever begin
      @(posedge clock);
      ldFlag = IRin;
      if (ldFlag) begin
        #2;
        IR = pendingIr;
      end
    end
  end

  initial begin
    logic [33:0] exp;
    forever begin
      @(posedge clock);
      if (!done) begin
        exp = expectVec(mHalted, !clear, mStep, IR[31:27], CON);
        total++;
        if (dutVec !== exp) begin
          bad++;
          $display("[TB] FAIL cycle_compare t=%0t step=%0d ir=%h got=%h expected=%h",
                   $time, mStep, IR, dutVec, exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [33:0] actual,
                             input logic [33:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Runs one instruction starting in T0; records outputs per step.
  task automatic applyStimulus(input logic [31:0] ir, input logic con,
                               input int stopStep, output int cycles);
    pendingIr = ir;
    CON = con;
    cycles = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock);
      snap[mStep] = dutVec;
      cycles++;
      if (mStep == stopStep) begin
        #2;
        stop = 1'b1;
      end
      @(negedge clock);
      #2;
      stop = 1'b0;
      if (mStep == 0 || mHalted) return;
    end
    total++;
    bad++;
    $display("[TB] FAIL timeout: got=%0d cycles expected=instruction end", cycles);
  endtask

  logic [31:0] progIr [15] = '{32'h0880_0005, 32'h6100_0010, 32'h6900_000F,
                               32'h7100_0003, 32'h5880_0000, 32'h2000_0000,
                               32'hA880_0000, 32'hA080_0000, 32'hB080_0000,
                               32'hB880_0000, 32'hC080_0000, 32'hC880_0000,
                               32'hD000_0000, 32'hF800_0000, 32'h9000_0000};
  int progLat [15] = '{6, 6, 6, 6, 6, 6, 5, 4, 4, 4, 4, 4, 3, 3, 3};

  initial begin
    int cyc;
    bit found;
    #2;
    checkOutput("reset_state", dutVec, {1'b1, 33'b0});
    @(negedge clock);
    #2;
    clear = 1'b1;

    applyStimulus(32'h1080_0068, 1'b0, -1, cyc);
    checkCount("st_cycles", cyc, 8);
    checkOutput("st_t0", snap[0], {1'b1, 5'd0, PCOUT | MARIN | INCPC});
    checkOutput("st_t4", snap[4], {1'b1, 5'b00011, COUT | ZLOIN});
    checkOutput("st_t7", snap[7], {1'b1, 5'd0, WRITE | RAMEN});

    applyStimulus(32'h1889_8000, 1'b0, -1, cyc);
    checkCount("add_cycles", cyc, 6);
    checkOutput("add_t4", snap[4], {1'b1, 5'b00011, GRC | ROUT | ZLOIN});
    checkOutput("add_t5", snap[5], {1'b1, 5'd0, ZOUT | GRA | RIN});

    applyStimulus(32'h9880_0004, 1'b0, -1, cyc);
    checkCount("br_con0_cycles", cyc, 7);
    checkOutput("br_con0_t6", snap[6], {1'b1, 5'd0, ZOUT});
    applyStimulus(32'h9880_0004, 1'b1, -1, cyc);
    checkCount("br_con1_cycles", cyc, 7);
    checkOutput("br_con1_t6", snap[6], {1'b1, 5'd0, ZOUT | PCIN});

    applyStimulus(32'h7800_0000, 1'b0, -1, cyc);
    checkCount("mul_as_nop_cycles", cyc, 3);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(progIr[i], 1'b0, -1, cyc);
      checkCount($sformatf("latency_%h", progIr[i]), cyc, progLat[i]);
    end

    applyStimulus(32'h0080_0010, 1'b0, 4, cyc);
    checkCount("ld_stop_cycles", cyc, 8);
    checkOutput("ld_t7", snap[7], {1'b1, 5'd0, MDROUT | GRA | RIN});
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checkOutput("halt_hold", dutVec, 34'b0);
    end
    @(negedge clock);
    #2;
    clear = 1'b0;
    @(negedge clock);
    #2;
    clear = 1'b1;

    applyStimulus(32'hD800_0000, 1'b0, -1, cyc);
    checkCount("halt_instr_cycles", cyc, 3);
    repeat (3) @(negedge clock);
    #2;
    clear = 1'b0;
    @(negedge clock);
    #2;
    clear = 1'b1;

    pendingIr = 32'h1080_0068;
    found = 1'b0;
    for (int n = 0; n < 12 && !found; n++) begin
      @(posedge clock);
      if (mStep == 5) found = 1'b1;
    end
    checkCount("reach_st_t5", int'(found), 1);
    #2;
    clear = 1'b0;
    #1;
    checkOutput("clear_mid_st", dutVec, {1'b1, 33'b0});
    @(negedge clock);
    #2;
    clear = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("after_clear_t0", dutVec, {1'b1, 5'd0, PCOUT | MARIN | INCPC});

    repeat (20) @(negedge clock);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
